// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Overflow saturation is built only when BCD_OVF_EN is defined.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE    = 4'h9;
    localparam bcd_digit_t BCD_ADD3_TH = 4'h5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } conv_state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake bundle between the datapath and the converter.
// The Overflow signal exists only when BCD_OVF_EN is defined.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
);

    logic                  Start;
    logic [BIN_W-1:0]      Bin;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   Bcd;
`ifdef BCD_OVF_EN
    logic                  Overflow;

    modport master (
        output Start, Bin,
        input  Busy, Done, Bcd, Overflow
    );

    modport slave (
        input  Start, Bin,
        output Busy, Done, Bcd, Overflow
    );
`else
    modport master (
        output Start, Bin,
        input  Busy, Done, Bcd
    );

    modport slave (
        input  Start, Bin,
        output Busy, Done, Bcd
    );
`endif

endinterface

// File: rtl/bcd_add3.sv
// One-digit double-dabble correction: add 3 to any digit of 5 or more.
// Inputs are legal BCD (0..9), so the result never exceeds 4'hC.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t fixed
);

    assign fixed = (digit >= BCD_ADD3_TH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one shift per clock, start/busy/done.
// With BCD_OVF_EN defined, out-of-range inputs saturate to all nines.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic               Clock,
    input  logic               Resetn,
    bin_to_bcd_seq_if.slave    bus
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    conv_state_t      state;
    logic [BIN_W-1:0] bin_sr;
    logic [DW-1:0]    dig;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic [DW-1:0]    bcd;

    logic [DW-1:0]    fixed;
    logic [DW-1:0]    dig_next;
    logic [BIN_W-1:0] bin_next;
    logic             last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (dig[4*i +: 4]),
            .fixed (fixed[4*i +: 4])
        );
    end

    assign dig_next = {fixed[DW-2:0], bin_sr[BIN_W-1]};
    assign bin_next = {bin_sr[BIN_W-2:0], 1'b0};
    assign last     = (count == CW'(BIN_W - 1));

`ifdef BCD_OVF_EN
    logic ovf;
    logic ovf_next;
    logic overflow;

    // The bit leaving the top digit is a hundreds carry: sticky out-of-range.
    assign ovf_next     = ovf | fixed[DW-1];
    assign bus.Overflow = overflow;
`else
    logic carry_unused;

    assign carry_unused = fixed[DW-1];
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= S_IDLE;
            bin_sr <= '0;
            dig    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
`ifdef BCD_OVF_EN
            ovf      <= 1'b0;
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        bin_sr <= bus.Bin;
                        dig    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
`ifdef BCD_OVF_EN
                        ovf    <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    bin_sr <= bin_next;
                    dig    <= dig_next;
                    count  <= count + 1'b1;
`ifdef BCD_OVF_EN
                    ovf    <= ovf_next;
`endif
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
`ifdef BCD_OVF_EN
                        bcd      <= ovf_next ? {DIGITS{BCD_NINE}}
                                             : dig_next;
                        overflow <= ovf_next;
`else
                        bcd <= dig_next;
`endif
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.Bcd  = bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: handshake timing, abort, and a full sweep.
// Expectations follow BCD_OVF_EN (saturate) or its absence (mod 100).
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 7;
    localparam int DIGITS = 2;

`ifdef BCD_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic Clock;
    logic Resetn;
    int   n_checks = 0;
    int   n_pass   = 0;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_bcd(input int v);
        int m;
        if (OVF_EN && v > 99) return 8'h99;
        m = v % 100;
        return 8'((m / 10) * 16 + (m % 10));
    endfunction

    // One conversion from IDLE; returns with the DUT back in IDLE.
    task automatic run_conv(input logic [6:0] v, input logic [7:0] exp_bcd,
                            input logic exp_ovf);
        int lat;
        int busy_n;
        bit seen;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Bin   = v;
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        bus.Bin   = 7'($urandom);
        busy_n = bus.Busy ? 1 : 0;
        lat    = 0;
        seen   = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge Clock);
            #1;
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check("latency", lat, BIN_W);
        check("bcd", exp_bcd, bus.Bcd === exp_bcd ? exp_bcd : bus.Bcd);
`ifdef BCD_OVF_EN
        check("overflow", bus.Overflow, exp_ovf);
`else
        if (exp_ovf) check("ovf_arg", 1, 0);
`endif
        @(posedge Clock);
        #1;
        check("done_width", bus.Done, 0);
        check("busy_idle", bus.Busy, 0);
        check("busy_cycles", busy_n, BIN_W + 1);
    endtask

    initial begin
        int           t4_at[4]  = '{7, 16, 25, 34};
        logic [7:0]   t4_bcd[4] = '{8'h01, 8'h28, 8'h55, 8'h82};
        int           done_j[$];
        logic [7:0]   done_bcd[$];
        int           no_done;

        Resetn    = 1'b0;
        bus.Start = 1'b0;
        bus.Bin   = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_bcd", bus.Bcd, 0);
`ifdef BCD_OVF_EN
        check("rst_ovf", bus.Overflow, 0);
`endif
        @(negedge Clock);
        Resetn = 1'b1;

        run_conv(7'd0,  8'h00, 1'b0);
        run_conv(7'd57, 8'h57, 1'b0);
        run_conv(7'd99, 8'h99, 1'b0);
        run_conv(7'd10, 8'h10, 1'b0);
        if (OVF_EN) run_conv(7'd127, 8'h99, 1'b1);
        else        run_conv(7'd127, 8'h27, 1'b0);
        run_conv(7'd5, 8'h05, 1'b0);

        repeat (4) @(posedge Clock);
        #1;
        check("hold_bcd", bus.Bcd, 8'h05);

        // Start held high, Bin = 3*j+1 at edge j; accepts at j = 0, 9, 18, 27.
        for (int j = 0; j < 36; j++) begin
            @(negedge Clock);
            bus.Start = 1'b1;
            bus.Bin   = 7'(3 * j + 1);
            @(posedge Clock);
            #1;
            if (bus.Done) begin
                done_j.push_back(j);
                done_bcd.push_back(bus.Bcd);
            end
        end
        bus.Start = 1'b0;
        check("t4_count", done_j.size(), 4);
        for (int n = 0; n < 4 && n < done_j.size(); n++) begin
            check("t4_at", done_j[n], t4_at[n]);
            check("t4_bcd", done_bcd[n], t4_bcd[n]);
        end
        repeat (12) @(posedge Clock);

        // Abort at the third shift.
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Bin   = 7'd57;
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        check("abort_busy", bus.Busy, 0);
        check("abort_bcd", bus.Bcd, 0);
        check("abort_done", bus.Done, 0);
`ifdef BCD_OVF_EN
        check("abort_ovf", bus.Overflow, 0);
`endif
        @(negedge Clock);
        Resetn  = 1'b1;
        no_done = 0;
        repeat (12) begin
            @(posedge Clock);
            #1;
            if (bus.Done || bus.Busy) no_done++;
        end
        check("abort_quiet", no_done, 0);
        run_conv(7'd33, 8'h33, 1'b0);

        for (int v = 0; v < 128; v++)
            run_conv(7'(v), ref_bcd(v), OVF_EN && (v > 99));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
